// File: rtl/nash_stream_cipher.sv
// nash_stream_cipher: WIDTH-bit xorshift stream cipher with valid/ready handshakes and per-frame rewind
// Define NASH_ZERO_SEED_GUARD_EN to replace an all-zero seed with a nonzero constant
module nash_stream_cipher #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             keyed,
    output logic [CNT_W-1:0] beat_count
);
    logic [WIDTH-1:0] seed_r, s, s_next, t0, t1, seed_eff;
    logic accept;
    always_comb begin
        t0 = s ^ (s << 13);
        t1 = t0 ^ (t0 >> 7);
        s_next = t1 ^ (t1 << 17);
    end
`ifdef NASH_ZERO_SEED_GUARD_EN
    // zero is a fixed point of xorshift, so it would leave the data unencrypted
    assign seed_eff = (seed == '0) ? {(WIDTH/32){32'h9E3779B9}} : seed;
`else
    assign seed_eff = seed;
`endif
    assign in_ready = keyed & ~seed_load & (~out_valid | out_ready);
    assign accept = in_valid & in_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seed_r <= '0;
            s <= '0;
            keyed <= 1'b0;
            beat_count <= '0;
            out_data <= '0;
            out_last <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (seed_load) begin
                seed_r <= seed_eff;
                s <= seed_eff;
                keyed <= 1'b1;
                beat_count <= '0;
            end else if (accept) begin
                s <= in_last ? seed_r : s_next;
                beat_count <= beat_count + CNT_W'(1);
            end
            if (accept) begin
                out_data <= in_data ^ s;
                out_last <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_nash_stream_cipher.sv
// tb_nash_stream_cipher: scoreboard bench for nash_stream_cipher (WIDTH=128, narrow beat counter to reach wrap)
module tb_nash_stream_cipher;
    localparam int CW = 4;
    localparam logic [127:0] K1 = 128'hDEADBEEFCAFEBABE1234567890ABCDEF;
    localparam logic [127:0] K2 = 128'h0123456789ABCDEF0F1E2D3C4B5A6978;
    localparam logic [127:0] K3 = 128'h55AA55AA00FF00FFA5A5A5A53C3C3C3C;
`ifdef NASH_ZERO_SEED_GUARD_EN
    localparam logic [127:0] GUARD = {4{32'h9E3779B9}};
`else
    localparam logic [127:0] GUARD = '0;
`endif

    logic clk = 1'b0;
    logic reset, seed_load, in_valid, in_last, out_ready = 1'b0;
    logic [127:0] seed, in_data;
    logic in_ready, out_valid, out_last, keyed;
    logic [127:0] out_data;
    logic [CW-1:0] beat_count;

    nash_stream_cipher #(.WIDTH(128), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .keyed(keyed), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, stall_tot = 0;
    logic bp_en = 1'b0, stall = 1'b0, cap_en = 1'b0;
    logic [128:0] sb[$];
    logic [127:0] cap[$], ct[$], pts[$];
    logic lst[$];
    logic [127:0] m_seed = '0, m_s = '0;
    logic [CW-1:0] m_cnt = '0;

    always @(posedge clk) begin
        #1;
        out_ready = bp_en ? 1'($urandom_range(0, 1)) : ~stall;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] nx(input logic [127:0] v);
        logic [127:0] t;
        t = v ^ (v << 13);
        t = t ^ (t >> 7);
        return t ^ (t << 17);
    endfunction

    function automatic logic [127:0] pt8(input int i);
        return {4{32'h1111_1111 * 32'(i + 1)}};
    endfunction

    // monitor: pops on every delivered beat, checks hold stability while stalled
    logic held = 1'b0, held_l;
    logic [127:0] held_d;
    logic [128:0] e;
    always @(negedge clk) begin
        if (!reset || !out_valid) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_data", out_data, held_d);
                check("hold_last", out_last, held_l);
            end
            if (out_ready) begin
                held = 1'b0;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_beat: got %h with no expected beat queued", out_data);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e[127:0]);
                    check("out_last", out_last, e[128]);
                    if (cap_en) cap.push_back(out_data);
                end
            end else begin
                held = 1'b1;
                held_d = out_data;
                held_l = out_last;
            end
        end
    end

    task automatic model_load(input logic [127:0] v);
        m_seed = (v == '0) ? GUARD : v;
        m_s = m_seed;
        m_cnt = '0;
    endtask

    task automatic load(input logic [127:0] v);
        seed = v;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        model_load(v);
    endtask

    task automatic send(input logic [127:0] d, input logic l);
        int w = 0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        @(negedge clk);
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        stall_tot += w;
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back({l, d ^ m_s});
        m_s = l ? m_seed : nx(m_s);
        m_cnt = CW'(m_cnt + 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_outstanding", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        logic l;
        reset = 1'b0; seed = '0; seed_load = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {in_ready, out_valid, out_last, keyed}, 0);
        check("rst_data", out_data, 0);
        check("rst_cnt", beat_count, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_rdy_vld_keyed", {in_ready, out_valid, keyed}, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        load(K1);
        check("keyed", keyed, 1);
        send({4{32'hFACEFACE}}, 1'b1);
        check("vec_valid", out_valid, 1);
        check("vec_data", out_data, 128'h2463442130304070E8FAACB66A653721);
        check("vec_cnt", beat_count, 1);
        drain();

        // two identical frames: ciphertext repeats, then decrypt back
        cap.delete(); cap_en = 1'b1; stall_tot = 0;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < 8; i++) send(pt8(i), i == 7);
        drain();
        cap_en = 1'b0;
        check("frame_stalls", stall_tot, 0);
        check("frame_cnt_wrap", beat_count, 1);
        check("frame_len", cap.size(), 16);
        if (cap.size() == 16) begin
            for (int i = 0; i < 8; i++) check("rewind", cap[i + 8], cap[i]);
            ct = cap;
            load(K1);
            cap.delete(); cap_en = 1'b1;
            for (int i = 0; i < 16; i++) send(ct[i], i % 8 == 7);
            drain();
            cap_en = 1'b0;
            check("rt8_len", cap.size(), 16);
            for (int i = 0; i < 16 && i < cap.size(); i++) check("roundtrip8", cap[i], pt8(i % 8));
        end

        // random backpressure round trip
        load(K2);
        cap.delete(); cap_en = 1'b1; bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            l = (i == 999) || ($urandom_range(0, 7) == 0);
            pts.push_back(d);
            lst.push_back(l);
            send(d, l);
        end
        drain();
        cap_en = 1'b0;
        check("bp_cnt", beat_count, m_cnt);
        check("bp_len", cap.size(), 1000);
        ct = cap;
        load(K2);
        cap.delete(); cap_en = 1'b1;
        for (int i = 0; i < ct.size(); i++) send(ct[i], lst[i]);
        drain();
        cap_en = 1'b0; bp_en = 1'b0;
        check("bp_rt_len", cap.size(), 1000);
        for (int i = 0; i < 1000 && i < cap.size(); i++)
            if (cap[i] !== pts[i]) check("bp_roundtrip", cap[i], pts[i]);
        check("bp_roundtrip_last", cap.size() > 0 ? cap[cap.size() - 1] : '0, pts[999]);

        // seed_load collides with in_valid mid-frame
        load(K1);
        send(128'hA, 1'b0);
        send(128'hB, 1'b0);
        in_valid = 1'b1; in_data = 128'hC0FFEE; in_last = 1'b0;
        seed = K3; seed_load = 1'b1;
        @(negedge clk);
        check("sl_in_ready", in_ready, 0);
        @(posedge clk); #1;
        seed_load = 1'b0;
        model_load(K3);
        send(128'hC0FFEE, 1'b0);
        check("sl_data", out_data, 128'hC0FFEE ^ K3);
        check("sl_cnt", beat_count, 1);
        drain();

        // zero seed
        load('0);
        send(128'h00112233445566778899AABBCCDDEEFF, 1'b0);
        check("zero_data", out_data, 128'h00112233445566778899AABBCCDDEEFF ^ GUARD);
        send(128'h1, 1'b0);
        send(128'h2, 1'b1);
        drain();

        // reset while a beat is stalled in the output register
        stall = 1'b1;
        @(posedge clk); #1;
        send(128'hBAD, 1'b1);
        repeat (2) @(negedge clk);
        check("stall_valid", out_valid, 1);
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_flags", {out_valid, out_last, keyed}, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_cnt", beat_count, 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        stall = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {in_ready, keyed}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
